// File: rtl/mealy_panel.sv
// mealy_panel: front-panel controller. Synchronises and debounces raw board
// inputs, applies one button action per cycle to an N-digit hex register at
// an editing cursor, and scans the digits onto a multiplexed active-low
// 7-segment display whose decimal point marks the cursor.
module mealy_panel #(
  parameter int NUM_DIGITS = 4,
  parameter int DEBOUNCE_W = 16,
  parameter int SCAN_W     = 16
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic [3:0]              sw,
  input  logic [3:0]              btn,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [4*NUM_DIGITS-1:0] value
);

  localparam int CUR_W = $clog2(NUM_DIGITS);
  localparam logic [DEBOUNCE_W-1:0] DEBOUNCE_MAX = '1;
  localparam logic [CUR_W-1:0]      LAST_DIGIT   = CUR_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC,
    ACT_CURSOR
  } action_e;

  logic [3:0]                   sw_meta_q, sw_sync_q;
  logic [3:0]                   btn_meta_q, btn_sync_q;
  logic [3:0][DEBOUNCE_W-1:0]   cnt_q, cnt_d;
  logic [3:0]                   db_q, db_d, db_dly_q;
  logic [3:0]                   press;
  logic [4*NUM_DIGITS-1:0]      digits_q, digits_d;
  logic [CUR_W-1:0]             cursor_q, cursor_d;
  logic [CUR_W-1:0]             scan_q, scan_d;
  logic [SCAN_W-1:0]            presc_q;
  logic [3:0]                   scan_digit;
  action_e                      action;

  // Two-flop synchronisers for the asynchronous switch and button pins.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Debounce: a level change is accepted only after it has persisted long
  // enough for the counter to saturate, then the counter restarts.
  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a variable
    // unassigned and no latch is inferred.
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int b = 0; b < 4; b++) begin
      if (btn_sync_q[b] == db_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == DEBOUNCE_MAX) begin
        db_d[b]  = btn_sync_q[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  // Debounce counters, debounced levels and their one-cycle delayed copies.
  // NOTE: the counter array is part of the reset domain; a half-counted
  // glitch must not survive a reset and complete afterwards.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      cnt_q    <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  // Rising edges of the debounced levels; releases are ignored.
  assign press = db_q & ~db_dly_q;

  // Pick the single winning action; lower-priority presses are dropped.
  always_comb begin
    action = ACT_NONE;
    if      (press[3]) action = ACT_LOAD;
    else if (press[0]) action = ACT_INC;
    else if (press[1]) action = ACT_DEC;
    else if (press[2]) action = ACT_CURSOR;
  end

  // Apply the action to the digit under the cursor, or move the cursor.
  always_comb begin
    digits_d = digits_q;
    cursor_d = cursor_q;
    if (action == ACT_CURSOR) begin
      cursor_d = (cursor_q == LAST_DIGIT) ? '0 : cursor_q + 1'b1;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CUR_W'(i) == cursor_q) begin
        unique case (action)
          ACT_LOAD: digits_d[4*i +: 4] = sw_sync_q;
          ACT_INC:  digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          ACT_DEC:  digits_d[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
          default:  ;
        endcase
      end
    end
  end

  // Scan index advances once per full prescaler period.
  always_comb begin
    scan_d = scan_q;
    if (presc_q == '1) begin
      scan_d = (scan_q == LAST_DIGIT) ? '0 : scan_q + 1'b1;
    end
  end

  // Digit register, cursor and display scan state.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      digits_q <= '0;
      cursor_q <= '0;
      scan_q   <= '0;
      presc_q  <= '0;
    end else begin
      digits_q <= digits_d;
      cursor_q <= cursor_d;
      scan_q   <= scan_d;
      presc_q  <= presc_q + 1'b1;
    end
  end

  // Select the digit currently being scanned out.
  always_comb begin
    scan_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CUR_W'(i) == scan_q) scan_digit = digits_q[4*i +: 4];
    end
  end

  // Active-low hex to 7-segment decode, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    unique case (scan_digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  assign an    = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_q);
  assign dp    = ~(scan_q == cursor_q);
  assign value = digits_q;

endmodule

// File: tb/tb_mealy_panel.sv
// tb_mealy_panel: directed bench for mealy_panel with short debounce and
// scan periods (DEBOUNCE_W=2 -> 4-cycle debounce, SCAN_W=2 -> 4 cycles/digit).
module tb_mealy_panel;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sw;
  logic [3:0]  btn;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] value;

  int checks = 0;
  int errors = 0;

  mealy_panel #(
    .NUM_DIGITS (4),
    .DEBOUNCE_W (2),
    .SCAN_W     (2)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .sw              (sw),
    .btn             (btn),
    .an              (an),
    .seg             (seg),
    .dp              (dp),
    .value           (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Press, hold through the action edge (edge 7), release and let it settle.
  task automatic press(input logic [3:0] mask);
    btn = mask;
    tick(7);
    btn = 4'b0000;
    tick(10);
  endtask

  // Step until the given digit is being scanned; bounded, checked either way.
  task automatic find_digit(input int j);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << j);
    n = 0;
    while (an !== want && n < 40) begin
      tick(1);
      n++;
    end
    check($sformatf("find_an_k%0d", j), {28'd0, an}, {28'd0, want});
  endtask

  logic [6:0] seg_exp [4];

  initial begin
    seg_exp[0] = 7'b1111001;  // 1
    seg_exp[1] = 7'b0100100;  // 2
    seg_exp[2] = 7'b0110000;  // 3
    seg_exp[3] = 7'b0011001;  // 4
    sw  = 4'h0;
    btn = 4'h0;

    // Reset before any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_an",    {28'd0, an},  32'h0000_000E);
    check("rst_seg",   {25'd0, seg}, 32'h0000_0040);
    check("rst_dp",    {31'd0, dp},  32'h0);
    check("rst_value", {16'd0, value}, 32'h0);
    tick(3);
    check("rst_held_an", {28'd0, an}, 32'h0000_000E);
    rst_n = 1'b1;

    // Increment latency, hold without repeat, second press.
    btn = 4'b0001;
    tick(6);
    check("inc_edge6", {16'd0, value}, 32'h0000);
    tick(1);
    check("inc_edge7", {16'd0, value}, 32'h0001);
    tick(20);
    check("inc_held", {16'd0, value}, 32'h0001);
    btn = 4'b0000;
    tick(10);
    press(4'b0001);
    check("inc_second", {16'd0, value}, 32'h0002);

    // Glitch rejection then decrement wrap.
    do_reset();
    btn = 4'b0010;
    tick(3);
    btn = 4'b0000;
    tick(15);
    check("glitch", {16'd0, value}, 32'h0000);
    press(4'b0010);
    check("dec_wrap", {16'd0, value}, 32'h000F);

    // Cursor movement, dp placement, wrap and load.
    do_reset();
    repeat (3) press(4'b0100);
    find_digit(3);
    check("cur3_dp_on", {31'd0, dp}, 32'h0);
    find_digit(0);
    check("cur3_dp_off0", {31'd0, dp}, 32'h1);
    press(4'b0100);
    find_digit(0);
    check("cur0_dp_on", {31'd0, dp}, 32'h0);
    find_digit(3);
    check("cur0_dp_off3", {31'd0, dp}, 32'h1);
    repeat (3) press(4'b0100);
    sw = 4'hA;
    press(4'b1000);
    check("load_cur3", {16'd0, value}, 32'hA000);

    // Simultaneous presses: load beats increment, increment beats cursor.
    do_reset();
    sw = 4'h5;
    press(4'b1001);
    check("prio_load_inc", {16'd0, value}, 32'h0005);
    press(4'b0101);
    check("prio_inc_cur", {16'd0, value}, 32'h0006);
    find_digit(0);
    check("prio_cursor_kept", {31'd0, dp}, 32'h0);

    // Build 0x4321 and watch the scan.
    do_reset();
    sw = 4'h1; press(4'b1000); press(4'b0100);
    sw = 4'h2; press(4'b1000); press(4'b0100);
    sw = 4'h3; press(4'b1000); press(4'b0100);
    sw = 4'h4; press(4'b1000);
    check("build_4321", {16'd0, value}, 32'h4321);
    find_digit(3);
    find_digit(0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("scan_an%0d", j),  {28'd0, an},  {28'd0, ~(4'b0001 << j)});
      check($sformatf("scan_seg%0d", j), {25'd0, seg}, {25'd0, seg_exp[j]});
      tick(3);
      check($sformatf("scan_hold%0d", j), {28'd0, an}, {28'd0, ~(4'b0001 << j)});
      tick(1);
    end
    check("scan_wrap", {28'd0, an}, 32'h0000_000E);

    // Asynchronous reset mid-debounce and mid-scan.
    tick(2);
    btn = 4'b0001;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an",    {28'd0, an},  32'h0000_000E);
    check("mid_rst_seg",   {25'd0, seg}, 32'h0000_0040);
    check("mid_rst_dp",    {31'd0, dp},  32'h0);
    check("mid_rst_value", {16'd0, value}, 32'h0);
    btn = 4'b0000;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("no_stale_action", {16'd0, value}, 32'h0);

    // Button held through reset release counts as a fresh press.
    btn = 4'b0001;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("held_rst_edge6", {16'd0, value}, 32'h0000);
    tick(1);
    check("held_rst_edge7", {16'd0, value}, 32'h0001);
    btn = 4'b0000;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mealy_panel.md
# mealy_panel

Parametrised Mealy-style front-panel controller, the generalised successor to the fixed 4-digit switch/button machine. It turns raw board switches and push-buttons into edits of an N-digit hex value and drives a multiplexed, active-low 7-segment display. It adds three things the fixed machine lacks: input synchronisation, per-button debounce with single-cycle edge actions, and an editing cursor. It sits between the board I/O pins and the top-level display pins.

## Interface
- NUM_DIGITS, default 4: number of hex digits and anodes; must be at least 2.
- DEBOUNCE_W, default 16: debounce counter width. DEBOUNCE_MAX = 2^DEBOUNCE_W - 1.
- SCAN_W, default 16: scan prescaler width. The active digit advances every 2^SCAN_W cycles.
- system1000, input, 1: clock. All state changes on its rising edge.
- system1000_rstn, input, 1: asynchronous reset, active-low.
- sw, input, 4: raw switches, asynchronous to the clock.
- btn, input, 4: raw push-buttons, active-high, asynchronous to the clock.
  - btn[0]: increment. btn[1]: decrement. btn[2]: move cursor. btn[3]: load.
- an, output, NUM_DIGITS: anode enables, active-low, one-hot-low.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low. Lit on the digit under the cursor.
- value, output, 4*NUM_DIGITS: current digit register. Digit i occupies bits [4i+3:4i].

## Operation
- Synchronisers: two-flop chain per sw and btn bit, giving s_sw and s_btn. Reset value 0.
- Debounce, per button:
  - Each button has a counter cnt (DEBOUNCE_W bits) and a debounced level db.
  - If s_btn == db: cnt <= 0.
  - If s_btn != db and cnt < DEBOUNCE_MAX: cnt <= cnt + 1.
  - If s_btn != db and cnt == DEBOUNCE_MAX: db <= s_btn and cnt <= 0.
  - A pulse shorter than DEBOUNCE_MAX+1 cycles is rejected.
- Edge detect: db_d is db registered. Press event = db & ~db_d, one cycle wide. Releases produce no action.
- Action, one per cycle, priority btn3 > btn0 > btn1 > btn2:
  - Load: digit[cursor] <= s_sw.
  - Increment: digit[cursor] <= digit[cursor] + 1, mod 16 (F wraps to 0).
  - Decrement: digit[cursor] <= digit[cursor] - 1, mod 16 (0 wraps to F).
  - Cursor: cursor <= cursor + 1, wrapping NUM_DIGITS-1 to 0.
  - Lower-priority simultaneous events are dropped, not queued.
- Cursor register width is clog2(NUM_DIGITS).
- Scan:
  - The prescaler increments every cycle.
  - When the prescaler is all-ones, scan index k advances, wrapping NUM_DIGITS-1 to 0.
- Render (Mealy outputs, combinational from registered state):
  - an = ~(1 << k).
  - seg = hex7seg(digit[k]), full 0-F decode, active-low.
  - dp = ~(k == cursor).
- Reset (asynchronous, any time, including mid-debounce or mid-scan): every register returns to its reset value immediately.
  - Reset state: digits 0, cursor 0, k 0, prescaler 0, all cnt/db/db_d 0, synchronisers 0.
  - A button held through reset release is treated as a new press after the full debounce latency.

## Timing
- Reset output values for NUM_DIGITS=4:
  - an = 4'b1110, seg = 7'b1000000, dp = 0, value = 0.
  - In general, an = all-ones except bit 0.
- Button latency: raw btn is high and stable before sampling edge 1.
  - Synchronised at edge 2.
  - db set at edge DEBOUNCE_MAX+3.
  - Action takes effect at edge DEBOUNCE_MAX+4, visible on value immediately after.
- Load samples s_sw at the action edge, i.e. the switches as they were 2 edges earlier.
- Scan: an/seg/dp change exactly 2^SCAN_W cycles apart. Full refresh period = NUM_DIGITS * 2^SCAN_W cycles.
- Outputs are combinational from registers. There are no combinational paths from sw/btn to any output.

## Test plan
- Reset: assert rstn=0 with NUM_DIGITS=4 and DEBOUNCE_W=2 -> an=1110, seg=1000000, dp=0, value=0x0000, independent of the clock.
- Increment latency: hold btn[0] from edge 1 -> value=0x0001 after exactly edge 7, with no change earlier. Hold it 20 more cycles -> no further increments. Release and press again -> value=0x0002.
- Glitch rejection: btn[1] high for 3 cycles, then low (DEBOUNCE_W=2) -> value unchanged. Then a clean press from 0x0000 -> value=0x000F (decrement wrap).
- Cursor and load: press btn[2] three times -> cursor=3 and dp lit when an=0111. Press btn[2] once more -> cursor wraps to 0. Set cursor to 3, sw=0xA, press btn[3] -> value=0xA000.
- Simultaneous priority: btn[0] and btn[3] pressed on the same edge with sw=5 and cursor 0 -> value=0x0005, not incremented. btn[0] and btn[2] together -> digit incremented, cursor unchanged.
- Scan and mid-operation reset: with SCAN_W=2 and value=0x4321 -> an steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, every 4 cycles, with seg showing 1,2,3,4. Asserting rstn mid-debounce and mid-scan -> the reset values return immediately and no stale action fires after release.
